// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the instruction-cache frame record.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int DEF_NFRAMES = 16;
    localparam int IDX_W       = 4;
    localparam int TAG_W       = 26;

    // Wide enough for the smallest legal cache (2 frames); narrower tags are zero-extended.
    localparam int FRAME_TAG_W = 29;

    typedef logic [FRAME_TAG_W-1:0] ftag_t;

    typedef struct packed {
        logic  valid;
        ftag_t tag;
        word_t data;
    } frame_t;

endpackage

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-frame instruction cache with zero-cycle hits and a blocking fill.
module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int NFRAMES = DEF_NFRAMES
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IW = $clog2(NFRAMES);
    localparam int TW = 30 - IW;

    typedef enum logic {IDLE, FILL} state_t;

    state_t        state;
    state_t        next_state;
    frame_t        frames [NFRAMES];
    logic [29:0]   miss_waddr;

    logic [IW-1:0] req_idx;
    logic [TW-1:0] req_tag;
    logic [IW-1:0] fill_idx;
    logic [TW-1:0] fill_tag;
    frame_t        lookup;
    logic          tag_hit;
    logic          take_miss;
    logic          fill_done;
    logic          unused_ok;

    assign req_idx   = imemaddr[IW+1:2];
    assign req_tag   = imemaddr[31:IW+2];
    assign fill_idx  = miss_waddr[IW-1:0];
    assign fill_tag  = miss_waddr[29:IW];
    assign lookup    = frames[req_idx];
    assign tag_hit   = lookup.valid && (lookup.tag == ftag_t'(req_tag));
    assign unused_ok = ^imemaddr[1:0];

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        take_miss  = 1'b0;
        fill_done  = 1'b0;
        if (!RST) begin
            case (state)
                IDLE: begin
                    if (imemREN) begin
                        if (tag_hit) begin
                            ihit     = 1'b1;
                            imemload = lookup.data;
                        end else begin
                            take_miss  = 1'b1;
                            next_state = FILL;
                        end
                    end
                end
                FILL: begin
                    // The fill always finishes to the latched address, whatever the datapath does now.
                    iREN  = 1'b1;
                    iaddr = {miss_waddr, 2'b00};
                    if (!iwait) begin
                        fill_done  = 1'b1;
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            miss_waddr <= '0;
            for (int unsigned i = 0; i < NFRAMES; i++) begin
                frames[i[IW-1:0]].valid <= 1'b0;
            end
        end else begin
            state <= next_state;
            if (take_miss) begin
                miss_waddr <= imemaddr[31:2];
            end
            if (fill_done) begin
                frames[fill_idx] <= '{valid: 1'b1, tag: ftag_t'(fill_tag), data: iload};
            end
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct against an address-keyed cache model.
module tb_icache_direct;

    localparam int NF = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    always #5 CLK = ~CLK;

    icache_direct #(.NFRAMES(NF)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: per frame, the full word address it holds and its data; plus a pending fill.
    bit          m_valid [NF];
    logic [29:0] m_waddr [NF];
    logic [31:0] m_data  [NF];
    bit          m_fill  = 1'b0;
    logic [31:0] m_pend  = '0;
    logic [65:0] exp_v;

    function automatic int frame_of(input logic [31:0] a);
        return int'((a / 4) % NF);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int f = frame_of(a);
        return m_valid[f] && (m_waddr[f] == a[31:2]);
    endfunction

    // Expected {ihit, imemload, iREN, iaddr} for the inputs currently driven.
    function automatic logic [65:0] expect_out();
        if (RST) return '0;
        if (m_fill) return {1'b0, 32'h0, 1'b1, m_pend};
        if (imemREN && model_hit(imemaddr))
            return {1'b1, m_data[frame_of(imemaddr)], 1'b0, 32'h0};
        return '0;
    endfunction

    task automatic drive(input bit rst, input bit ren, input logic [31:0] a,
                         input bit w, input logic [31:0] ld);
        RST = rst; imemREN = ren; imemaddr = a; iwait = w; iload = ld;
        @(negedge CLK);
        exp_v = expect_out();
    endtask

    task automatic advance();
        @(posedge CLK);
        if (RST) begin
            foreach (m_valid[k]) m_valid[k] = 1'b0;
            m_fill = 1'b0;
            m_pend = '0;
        end else if (m_fill) begin
            if (!iwait) begin
                m_valid[frame_of(m_pend)] = 1'b1;
                m_waddr[frame_of(m_pend)] = m_pend[31:2];
                m_data[frame_of(m_pend)]  = iload;
                m_fill = 1'b0;
            end
        end else if (imemREN && !model_hit(imemaddr)) begin
            m_fill = 1'b1;
            m_pend = {imemaddr[31:2], 2'b00};
        end
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1), $urandom);
            n_checks++;
            if ({ihit, imemload, iREN, iaddr} !== 66'h0) begin
                n_fail++;
                $display("FAIL reset c%0d: got ihit=%b load=%h iREN=%b iaddr=%h, want all zero",
                         c, ihit, imemload, iREN, iaddr);
            end
            advance();
        end
    endtask

    task automatic test_miss_fill();
        drive(1'b0, 1'b1, 32'h4, 1'b1, 32'h0);
        n_checks++;
        if ({ihit, imemload, iREN, iaddr} !== exp_v) begin
            n_fail++;
            $display("FAIL miss_req: got %b %h %b %h, want %h", ihit, imemload, iREN, iaddr, exp_v);
        end
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b1, 32'h4, 1'b1, $urandom);
            n_checks++;
            if (ihit !== 1'b0 || iREN !== 1'b1 || iaddr !== 32'h4) begin
                n_fail++;
                $display("FAIL fill_wait c%0d: got ihit=%b iREN=%b iaddr=%h, want 0 1 00000004",
                         c, ihit, iREN, iaddr);
            end
            advance();
        end
        drive(1'b0, 1'b1, 32'h4, 1'b0, 32'h2001000A);
        n_checks++;
        if ({ihit, imemload, iREN, iaddr} !== exp_v) begin
            n_fail++;
            $display("FAIL fill_ready: got %b %h %b %h, want %h", ihit, imemload, iREN, iaddr, exp_v);
        end
        advance();
        drive(1'b0, 1'b1, 32'h4, 1'b1, 32'h0);
        n_checks++;
        if (ihit !== 1'b1 || imemload !== 32'h2001000A || iREN !== 1'b0) begin
            n_fail++;
            $display("FAIL first_hit: got ihit=%b load=%h iREN=%b, want 1 2001000a 0",
                     ihit, imemload, iREN);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b1, 32'h4, $urandom_range(0, 1), $urandom);
            n_checks++;
            if ({ihit, imemload, iREN, iaddr} !== {1'b1, 32'h2001000A, 1'b0, 32'h0}) begin
                n_fail++;
                $display("FAIL back_to_back c%0d: got %b %h %b %h, want 1 2001000a 0 0",
                         c, ihit, imemload, iREN, iaddr);
            end
            advance();
        end
    endtask

    task automatic test_conflict();
        logic [31:0] seq [6] = '{32'h44, 32'h44, 32'h44, 32'h44, 32'h4, 32'h4};
        bit          wt  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b1, seq[c], wt[c], 32'hC0DE_0000 + 32'(c));
            n_checks++;
            if ({ihit, imemload, iREN, iaddr} !== exp_v) begin
                n_fail++;
                $display("FAIL conflict c%0d: got %b %h %b %h, want %h",
                         c, ihit, imemload, iREN, iaddr, exp_v);
            end
            advance();
        end
        // Flush the refill of 0x4 started above.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h2001000A);
        n_checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h4) begin
            n_fail++;
            $display("FAIL conflict_refill: got iREN=%b iaddr=%h, want 1 00000004", iREN, iaddr);
        end
        advance();
    endtask

    task automatic test_redirect();
        drive(1'b0, 1'b1, 32'h10, 1'b1, 32'h0);
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, c[0], 32'h80, 1'b1, $urandom);
            n_checks++;
            if (iREN !== 1'b1 || iaddr !== 32'h10 || ihit !== 1'b0) begin
                n_fail++;
                $display("FAIL redirect_hold c%0d: got iREN=%b iaddr=%h ihit=%b, want 1 00000010 0",
                         c, iREN, iaddr, ihit);
            end
            advance();
        end
        drive(1'b0, 1'b1, 32'h80, 1'b0, 32'h1111_0010);
        advance();
        drive(1'b0, 1'b1, 32'h80, 1'b1, 32'h0);
        n_checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_newmiss: got ihit=%b iREN=%b, want 0 0", ihit, iREN);
        end
        advance();
        drive(1'b0, 1'b1, 32'h80, 1'b0, 32'h2222_0080);
        advance();
        drive(1'b0, 1'b1, 32'h10, 1'b1, 32'h0);
        n_checks++;
        if (ihit !== 1'b1 || imemload !== 32'h1111_0010) begin
            n_fail++;
            $display("FAIL redirect_oldhit: got ihit=%b load=%h, want 1 11110010", ihit, imemload);
        end
        advance();
    endtask

    task automatic test_reset_mid_fill();
        drive(1'b0, 1'b1, 32'h200, 1'b1, 32'h0);
        advance();
        drive(1'b1, 1'b1, 32'h200, 1'b0, 32'hDEAD_BEEF);
        n_checks++;
        if ({ihit, imemload, iREN, iaddr} !== 66'h0) begin
            n_fail++;
            $display("FAIL rst_fill_outs: got %b %h %b %h, want all zero", ihit, imemload, iREN, iaddr);
        end
        advance();
        drive(1'b0, 1'b1, 32'h200, 1'b1, 32'h0);
        n_checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_fill_after: got ihit=%b iREN=%b iaddr=%h, want 0 0 0", ihit, iREN, iaddr);
        end
        advance();
        drive(1'b0, 1'b1, 32'h200, 1'b0, 32'h5A5A_0200);
        advance();
        drive(1'b0, 1'b1, 32'h200, 1'b1, 32'h0);
        n_checks++;
        if (ihit !== 1'b1 || imemload !== 32'h5A5A_0200) begin
            n_fail++;
            $display("FAIL rst_fill_refetch: got ihit=%b load=%h, want 1 5a5a0200", ihit, imemload);
        end
        advance();
    endtask

    task automatic test_idle_gap();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, (c % 2 == 0) ? 32'h200 : 32'h80, $urandom_range(0, 1), $urandom);
            n_checks++;
            if ({ihit, imemload, iREN, iaddr} !== 66'h0) begin
                n_fail++;
                $display("FAIL idle_gap c%0d: got %b %h %b %h, want all zero",
                         c, ihit, imemload, iREN, iaddr);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), a,
                  $urandom_range(0, 1), $urandom);
            n_checks++;
            if ({ihit, imemload, iREN, iaddr} !== exp_v) begin
                n_fail++;
                $display("FAIL random c%0d addr=%h: got %b %h %b %h, want %h",
                         c, a, ihit, imemload, iREN, iaddr, exp_v);
            end
            advance();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
        @(posedge CLK);
        #1;
        test_reset();
        test_miss_fill();
        test_back_to_back();
        test_conflict();
        test_redirect();
        test_reset_mid_fill();
        test_idle_gap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
